// File: rtl/pc_fetch_pipe.sv
// pc_fetch_pipe: fetch PC register, next-PC select and the F -> D -> D2 -> X
// pipeline registers (pc, instruction, valid) of the 6-stage RV32 front end.
// Stall freezes F/D/D2 and bubbles X; kill requests squash the entering slot.
module pc_fetch_pipe #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic [2:0]      pcsel,
    input  logic            kill_d_req,
    input  logic            kill_d2_req,
    input  logic            kill_x_req,
    input  logic [XLEN-1:0] imm_f,
    input  logic [XLEN-1:0] imm_d2,
    input  logic [XLEN-1:0] alu_x,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] pc_f,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_d2,
    output logic [XLEN-1:0] pc_x,
    output logic [XLEN-1:0] inst_f,
    output logic [XLEN-1:0] inst_d,
    output logic [XLEN-1:0] inst_d2,
    output logic [XLEN-1:0] inst_x,
    output logic            valid_f,
    output logic            valid_d,
    output logic            valid_d2,
    output logic            valid_x,
    output logic            redirect
);

    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    localparam logic [XLEN-1:0] LSB_MASK = ~XLEN'(1);

    logic [XLEN-1:0] r_pc_f;
    logic            r_valid_f;
    logic [XLEN-1:0] r_pc_d,   r_inst_d;
    logic            r_valid_d;
    logic [XLEN-1:0] r_pc_d2,  r_inst_d2;
    logic            r_valid_d2;
    logic [XLEN-1:0] r_pc_x,   r_inst_x;
    logic            r_valid_x;

    logic [XLEN-1:0] w_next_pc;
    logic            w_redirect;
    logic [XLEN-1:0] w_inst_f;

    // Next-PC select; codes 5..7 fall back to sequential fetch.
    always_comb begin
        w_next_pc  = r_pc_f + PC_STEP;
        w_redirect = 1'b0;
        case (pcsel)
            3'd1: w_next_pc = r_pc_f + imm_f;
            3'd2: begin
                w_next_pc  = alu_x & LSB_MASK;
                w_redirect = 1'b1;
            end
            3'd3: begin
                w_next_pc  = r_pc_d2 + imm_d2;
                w_redirect = 1'b1;
            end
            3'd4: begin
                w_next_pc  = r_pc_d2 + PC_STEP;
                w_redirect = 1'b1;
            end
            default: w_next_pc = r_pc_f + PC_STEP;
        endcase
    end

    assign w_inst_f = r_valid_f ? imem_rdata : NOP_INST;

    // Fetch PC: redirects override stall; the first edge out of reset only
    // validates the slot at RESET_PC so that address is not skipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_f    <= RESET_PC;
            r_valid_f <= 1'b0;
        end else begin
            r_valid_f <= 1'b1;
            if (w_redirect || (!stall && r_valid_f)) begin
                r_pc_f <= w_next_pc;
            end
        end
    end

    // F -> D register: kill squashes, stall holds, otherwise copy F.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_d    <= '0;
            r_inst_d  <= NOP_INST;
            r_valid_d <= 1'b0;
        end else begin
            if (!stall) begin
                r_pc_d <= r_pc_f;
            end
            if (kill_d_req) begin
                r_inst_d  <= NOP_INST;
                r_valid_d <= 1'b0;
            end else if (!stall) begin
                r_inst_d  <= w_inst_f;
                r_valid_d <= r_valid_f;
            end
        end
    end

    // D -> D2 register: kill squashes, stall holds, otherwise copy D.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_d2    <= '0;
            r_inst_d2  <= NOP_INST;
            r_valid_d2 <= 1'b0;
        end else begin
            if (!stall) begin
                r_pc_d2 <= r_pc_d;
            end
            if (kill_d2_req) begin
                r_inst_d2  <= NOP_INST;
                r_valid_d2 <= 1'b0;
            end else if (!stall) begin
                r_inst_d2  <= r_inst_d;
                r_valid_d2 <= r_valid_d;
            end
        end
    end

    // D2 -> X register: kill or stall inserts a bubble; pc_x holds on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_x    <= '0;
            r_inst_x  <= NOP_INST;
            r_valid_x <= 1'b0;
        end else begin
            if (!stall) begin
                r_pc_x <= r_pc_d2;
            end
            if (kill_x_req || stall) begin
                r_inst_x  <= NOP_INST;
                r_valid_x <= 1'b0;
            end else begin
                r_inst_x  <= r_inst_d2;
                r_valid_x <= r_valid_d2;
            end
        end
    end

    assign pc_f     = r_pc_f;
    assign pc_d     = r_pc_d;
    assign pc_d2    = r_pc_d2;
    assign pc_x     = r_pc_x;
    assign inst_f   = w_inst_f;
    assign inst_d   = r_inst_d;
    assign inst_d2  = r_inst_d2;
    assign inst_x   = r_inst_x;
    assign valid_f  = r_valid_f;
    assign valid_d  = r_valid_d;
    assign valid_d2 = r_valid_d2;
    assign valid_x  = r_valid_x;
    assign redirect = w_redirect;

endmodule

// File: tb/tb_pc_fetch_pipe.sv
// tb_pc_fetch_pipe: directed stimulus with hand-computed expectations queued
// into a scoreboard; a monitor process pops and compares them when due.
module tb_pc_fetch_pipe;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [2:0]  pcsel;
    logic        kill_d_req, kill_d2_req, kill_x_req;
    logic [31:0] imm_f, imm_d2, alu_x, imem_rdata;
    logic [31:0] pc_f, pc_d, pc_d2, pc_x;
    logic [31:0] inst_f, inst_d, inst_d2, inst_x;
    logic        valid_f, valid_d, valid_d2, valid_x;
    logic        redirect;

    pc_fetch_pipe #(
        .XLEN    (32),
        .RESET_PC(32'h0000_0000),
        .NOP_INST(NOP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .pcsel      (pcsel),
        .kill_d_req (kill_d_req),
        .kill_d2_req(kill_d2_req),
        .kill_x_req (kill_x_req),
        .imm_f      (imm_f),
        .imm_d2     (imm_d2),
        .alu_x      (alu_x),
        .imem_rdata (imem_rdata),
        .pc_f       (pc_f),
        .pc_d       (pc_d),
        .pc_d2      (pc_d2),
        .pc_x       (pc_x),
        .inst_f     (inst_f),
        .inst_d     (inst_d),
        .inst_d2    (inst_d2),
        .inst_x     (inst_x),
        .valid_f    (valid_f),
        .valid_d    (valid_d),
        .valid_d2   (valid_d2),
        .valid_x    (valid_x),
        .redirect   (redirect)
    );

    // Instruction memory model: a fixed scramble of the address.
    function automatic logic [31:0] im(input logic [31:0] a);
        return a ^ 32'h5A5A_0003;
    endfunction

    assign imem_rdata = im(pc_f);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output selectors for the scoreboard.
    localparam int S_PCF = 0, S_PCD = 1, S_PCD2 = 2, S_PCX = 3;
    localparam int S_IF = 4, S_ID = 5, S_ID2 = 6, S_IX = 7;
    localparam int S_VF = 8, S_VD = 9, S_VD2 = 10, S_VX = 11, S_RD = 12;

    typedef struct {
        int          cyc;
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    event sample_ev;

    function automatic logic [31:0] get_out(input int sel);
        case (sel)
            S_PCF:   return pc_f;
            S_PCD:   return pc_d;
            S_PCD2:  return pc_d2;
            S_PCX:   return pc_x;
            S_IF:    return inst_f;
            S_ID:    return inst_d;
            S_ID2:   return inst_d2;
            S_IX:    return inst_x;
            S_VF:    return {31'd0, valid_f};
            S_VD:    return {31'd0, valid_d};
            S_VD2:   return {31'd0, valid_d2};
            S_VX:    return {31'd0, valid_x};
            default: return {31'd0, redirect};
        endcase
    endfunction

    // Expectation for the state after the coming clock edge.
    task automatic expn(input string n, input int s, input logic [31:0] v);
        q.push_back('{cyc + 1, n, s, v});
    endtask

    // Expectation for the current cycle (combinational or async outputs).
    task automatic expc(input string n, input int s, input logic [31:0] v);
        q.push_back('{cyc, n, s, v});
    endtask

    task automatic exp_reset_c(input string tag);
        expc({tag, "_pc_f"},    S_PCF,  32'h0);
        expc({tag, "_pc_d"},    S_PCD,  32'h0);
        expc({tag, "_pc_d2"},   S_PCD2, 32'h0);
        expc({tag, "_pc_x"},    S_PCX,  32'h0);
        expc({tag, "_inst_f"},  S_IF,   NOP);
        expc({tag, "_inst_d"},  S_ID,   NOP);
        expc({tag, "_inst_d2"}, S_ID2,  NOP);
        expc({tag, "_inst_x"},  S_IX,   NOP);
        expc({tag, "_valid_f"}, S_VF,   32'h0);
        expc({tag, "_valid_d"}, S_VD,   32'h0);
        expc({tag, "_valid_d2"},S_VD2,  32'h0);
        expc({tag, "_valid_x"}, S_VX,   32'h0);
    endtask

    task automatic drv(input logic st, input logic [2:0] sel, input logic kd,
                       input logic kd2, input logic kx, input logic [31:0] imf,
                       input logic [31:0] imd2, input logic [31:0] alu);
        stall       = st;
        pcsel       = sel;
        kill_d_req  = kd;
        kill_d2_req = kd2;
        kill_x_req  = kx;
        imm_f       = imf;
        imm_d2      = imd2;
        alu_x       = alu;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) -> sample_ev;

    // Monitor: compare every expectation that has come due.
    initial begin
        forever begin : mon
            int i;
            logic [31:0] got;
            @(sample_ev);
            i = 0;
            while (i < q.size()) begin
                if (q[i].cyc <= cyc) begin
                    got = get_out(q[i].sel);
                    n_checks++;
                    if (got !== q[i].val) begin
                        n_fail++;
                        $display("FAIL %s cyc=%0d got=%h expected=%h",
                                 q[i].name, cyc, got, q[i].val);
                    end
                    q.delete(i);
                end else begin
                    i++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        drv(0, 3'd0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        tick();
        tick();

        // c0: release reset; no edge yet so reset values still visible
        rst_n = 1'b1;
        exp_reset_c("rst");
        expc("c0_redirect", S_RD, 32'h0);
        expn("c1_pc_f", S_PCF, 32'h0);
        expn("c1_valid_f", S_VF, 32'h1);
        expn("c1_valid_d", S_VD, 32'h0);
        tick();
        // c1
        expc("c1_inst_f", S_IF, im(32'h0));
        expn("c2_pc_f", S_PCF, 32'h4);
        expn("c2_pc_d", S_PCD, 32'h0);
        expn("c2_valid_d", S_VD, 32'h1);
        expn("c2_inst_d", S_ID, im(32'h0));
        tick();
        // c2
        expn("c3_pc_f", S_PCF, 32'h8);
        expn("c3_valid_d2", S_VD2, 32'h1);
        expn("c3_inst_d2", S_ID2, im(32'h0));
        expn("c3_valid_x", S_VX, 32'h0);
        tick();
        // c3
        expn("c4_pc_f", S_PCF, 32'hC);
        expn("c4_pc_d2", S_PCD2, 32'h4);
        expn("c4_valid_x", S_VX, 32'h1);
        expn("c4_inst_x", S_IX, im(32'h0));
        expn("c4_pc_x", S_PCX, 32'h0);
        tick();
        // c4: JALR in X with all kills
        drv(0, 3'd2, 1, 1, 1, 32'h0, 32'h0, 32'h0000_0203);
        expc("jalr_redirect", S_RD, 32'h1);
        expn("jalr_pc_f", S_PCF, 32'h202);
        expn("jalr_valid_d", S_VD, 32'h0);
        expn("jalr_inst_d", S_ID, NOP);
        expn("jalr_pc_d", S_PCD, 32'hC);
        expn("jalr_valid_d2", S_VD2, 32'h0);
        expn("jalr_valid_x", S_VX, 32'h0);
        expn("jalr_inst_x", S_IX, NOP);
        expn("jalr_pc_x", S_PCX, 32'h4);
        tick();
        // c5: jump to 0x40
        drv(0, 3'd2, 0, 0, 0, 32'h0, 32'h0, 32'h40);
        expc("c5_inst_f", S_IF, im(32'h202));
        expn("c6_pc_f", S_PCF, 32'h40);
        expn("c6_pc_d", S_PCD, 32'h202);
        expn("c6_valid_d", S_VD, 32'h1);
        expn("c6_inst_d", S_ID, im(32'h202));
        tick();
        // c6: JAL in F
        drv(0, 3'd1, 0, 0, 0, 32'h100, 32'h0, 32'h0);
        expc("jal_redirect", S_RD, 32'h0);
        expn("jal_pc_f", S_PCF, 32'h140);
        expn("jal_pc_d", S_PCD, 32'h40);
        expn("jal_valid_d", S_VD, 32'h1);
        expn("jal_pc_d2", S_PCD2, 32'h202);
        expn("jal_valid_d2", S_VD2, 32'h1);
        tick();
        // c7: jump to 0x20
        drv(0, 3'd2, 0, 0, 0, 32'h0, 32'h0, 32'h20);
        expn("c8_pc_f", S_PCF, 32'h20);
        expn("c8_pc_x", S_PCX, 32'h202);
        expn("c8_valid_x", S_VX, 32'h1);
        tick();
        // c8
        drv(0, 3'd0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        expn("c9_pc_f", S_PCF, 32'h24);
        expn("c9_pc_d", S_PCD, 32'h20);
        tick();
        // c9
        expn("c10_pc_f", S_PCF, 32'h28);
        expn("c10_pc_d2", S_PCD2, 32'h20);
        expn("c10_pc_x", S_PCX, 32'h140);
        expn("c10_inst_x", S_IX, im(32'h140));
        tick();
        // c10: mispredicted branch in D2
        drv(0, 3'd3, 1, 1, 0, 32'h0, 32'hFFFF_FFF0, 32'h0);
        expc("br_redirect", S_RD, 32'h1);
        expn("br_pc_f", S_PCF, 32'h10);
        expn("br_valid_d", S_VD, 32'h0);
        expn("br_pc_d", S_PCD, 32'h28);
        expn("br_valid_d2", S_VD2, 32'h0);
        expn("br_inst_d2", S_ID2, NOP);
        expn("br_valid_x", S_VX, 32'h1);
        expn("br_inst_x", S_IX, im(32'h20));
        expn("br_pc_x", S_PCX, 32'h20);
        tick();
        // c11: jump to 0x31, bit 0 must be cleared
        drv(0, 3'd2, 0, 0, 0, 32'h0, 32'h0, 32'h31);
        expn("c12_pc_f", S_PCF, 32'h30);
        expn("c12_pc_d", S_PCD, 32'h10);
        expn("c12_valid_d", S_VD, 32'h1);
        tick();
        // c12: stall, first cycle
        drv(1, 3'd0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        expc("st1_redirect", S_RD, 32'h0);
        expn("st1_pc_f", S_PCF, 32'h30);
        expn("st1_pc_d", S_PCD, 32'h10);
        expn("st1_pc_d2", S_PCD2, 32'h28);
        expn("st1_valid_x", S_VX, 32'h0);
        expn("st1_inst_x", S_IX, NOP);
        expn("st1_pc_x", S_PCX, 32'h24);
        tick();
        // c13: stall, second cycle
        expn("st2_pc_f", S_PCF, 32'h30);
        expn("st2_pc_d", S_PCD, 32'h10);
        expn("st2_valid_d", S_VD, 32'h1);
        expn("st2_pc_d2", S_PCD2, 32'h28);
        expn("st2_valid_x", S_VX, 32'h0);
        tick();
        // c14: resume
        drv(0, 3'd0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        expn("rs1_pc_f", S_PCF, 32'h34);
        expn("rs1_pc_d", S_PCD, 32'h30);
        expn("rs1_valid_d", S_VD, 32'h1);
        expn("rs1_pc_d2", S_PCD2, 32'h10);
        expn("rs1_valid_d2", S_VD2, 32'h1);
        expn("rs1_pc_x", S_PCX, 32'h28);
        tick();
        // c15
        expn("rs2_pc_f", S_PCF, 32'h38);
        expn("rs2_pc_x", S_PCX, 32'h10);
        expn("rs2_valid_x", S_VX, 32'h1);
        expn("rs2_inst_x", S_IX, im(32'h10));
        tick();
        // c16
        expn("rs3_pc_f", S_PCF, 32'h3C);
        expn("rs3_pc_x", S_PCX, 32'h30);
        expn("rs3_valid_x", S_VX, 32'h1);
        expn("rs3_inst_x", S_IX, im(32'h30));
        tick();
        // c17: jump to the top of the address space
        drv(0, 3'd2, 0, 0, 0, 32'h0, 32'h0, 32'hFFFF_FFFC);
        expn("c18_pc_f", S_PCF, 32'hFFFF_FFFC);
        tick();
        // c18: sequential fetch wraps to 0
        drv(0, 3'd0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        expc("c18_inst_f", S_IF, im(32'hFFFF_FFFC));
        expn("wrap_pc_f", S_PCF, 32'h0);
        expn("wrap_pc_d", S_PCD, 32'hFFFF_FFFC);
        expn("wrap_inst_d", S_ID, im(32'hFFFF_FFFC));
        tick();
        // c19: jump to 0x80
        drv(0, 3'd2, 0, 0, 0, 32'h0, 32'h0, 32'h80);
        expn("c20_pc_f", S_PCF, 32'h80);
        tick();
        // c20
        drv(0, 3'd0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        expn("c21_pc_f", S_PCF, 32'h84);
        expn("c21_pc_d", S_PCD, 32'h80);
        tick();
        // c21
        expn("c22_pc_f", S_PCF, 32'h88);
        expn("c22_pc_d2", S_PCD2, 32'h80);
        expn("c22_pc_x", S_PCX, 32'h0);
        expn("c22_valid_x", S_VX, 32'h1);
        expn("c22_inst_x", S_IX, im(32'h0));
        tick();
        // c22: pcsel=4 with stall and kill_d; redirect wins over stall
        drv(1, 3'd4, 1, 0, 0, 32'h0, 32'h0, 32'h0);
        expc("s4_redirect", S_RD, 32'h1);
        expn("s4_pc_f", S_PCF, 32'h84);
        expn("s4_pc_d", S_PCD, 32'h84);
        expn("s4_valid_d", S_VD, 32'h0);
        expn("s4_inst_d", S_ID, NOP);
        expn("s4_pc_d2", S_PCD2, 32'h80);
        expn("s4_valid_d2", S_VD2, 32'h1);
        expn("s4_inst_d2", S_ID2, im(32'h80));
        expn("s4_valid_x", S_VX, 32'h0);
        expn("s4_pc_x", S_PCX, 32'h0);
        tick();
        // c23: pcsel=5 behaves as sequential fetch
        drv(0, 3'd5, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        expc("p5_redirect", S_RD, 32'h0);
        expn("p5_pc_f", S_PCF, 32'h88);
        expn("p5_pc_d", S_PCD, 32'h84);
        expn("p5_valid_d", S_VD, 32'h1);
        expn("p5_inst_d", S_ID, im(32'h84));
        expn("p5_pc_d2", S_PCD2, 32'h84);
        expn("p5_valid_d2", S_VD2, 32'h0);
        expn("p5_pc_x", S_PCX, 32'h80);
        expn("p5_valid_x", S_VX, 32'h1);
        expn("p5_inst_x", S_IX, im(32'h80));
        tick();
        // c24: asynchronous reset between clock edges
        drv(0, 3'd0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_reset_c("arst");
        -> sample_ev;
        #1;
        tick();
        tick();

        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 20 && q.size() != 0; k++) tick();
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain pending=%0d expected=0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
